// File: rtl/rs_alu.sv
// rs_alu: reservation station for arithmetic / branch-compare instructions.
// Buffers dispatched instructions, snoops the ALU and LSB result broadcasts to
// wake pending operands, and issues the lowest-index ready entry to the ALU
// each cycle through a registered issue port.
// Optional feature macro: RS_CDB_BYPASS_EN lets an entry woken by a broadcast
// issue in that same cycle, with the broadcast value muxed onto the operands.
module rs_alu #(
   parameter int RS_SIZE_BIT  = 3,
   parameter int RS_TYPE_BIT  = 5,
   parameter int ROB_SIZE_BIT = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    rob_clear,
   input  logic                    inst_valid,
   input  logic [RS_TYPE_BIT-1:0]  inst_type,
   input  logic [31:0]             inst_r1_val,
   input  logic [31:0]             inst_r2_val,
   input  logic                    inst_r1_has_dep,
   input  logic                    inst_r2_has_dep,
   input  logic [ROB_SIZE_BIT-1:0] inst_r1_dep,
   input  logic [ROB_SIZE_BIT-1:0] inst_r2_dep,
   input  logic [ROB_SIZE_BIT-1:0] inst_rob_id,
   output logic                    rs_full,
   input  logic                    alu_fi,
   input  logic [ROB_SIZE_BIT-1:0] alu_rob_id,
   input  logic [31:0]             alu_res,
   input  logic                    lsb_fi,
   input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
   input  logic [31:0]             lsb_res,
   output logic                    alu_input,
   output logic [RS_TYPE_BIT-1:0]  arith_type,
   output logic [31:0]             r1_val,
   output logic [31:0]             r2_val,
   output logic [ROB_SIZE_BIT-1:0] issue_rob_id
);

   localparam int RS_N = 1 << RS_SIZE_BIT;

   // control state (reset)
   logic [RS_N-1:0] busy_q, busy_d;
   logic [RS_N-1:0] p1_q, p1_d;
   logic [RS_N-1:0] p2_q, p2_d;
   logic                    alu_input_q, alu_input_d;
   logic [RS_TYPE_BIT-1:0]  arith_type_q, arith_type_d;
   logic [31:0]             r1_val_q, r1_val_d;
   logic [31:0]             r2_val_q, r2_val_d;
   logic [ROB_SIZE_BIT-1:0] issue_rob_id_q, issue_rob_id_d;

   // entry payload (not reset; qualified by busy/pending flags)
   logic [RS_TYPE_BIT-1:0]  ent_type_q [RS_N];
   logic [RS_TYPE_BIT-1:0]  ent_type_d [RS_N];
   logic [ROB_SIZE_BIT-1:0] ent_rob_q  [RS_N];
   logic [ROB_SIZE_BIT-1:0] ent_rob_d  [RS_N];
   logic [31:0]             v1_q [RS_N];
   logic [31:0]             v1_d [RS_N];
   logic [31:0]             v2_q [RS_N];
   logic [31:0]             v2_d [RS_N];
   logic [ROB_SIZE_BIT-1:0] q1_q [RS_N];
   logic [ROB_SIZE_BIT-1:0] q1_d [RS_N];
   logic [ROB_SIZE_BIT-1:0] q2_q [RS_N];
   logic [ROB_SIZE_BIT-1:0] q2_d [RS_N];

   // per-entry wakeup hits on each CDB port and issue readiness
   logic [RS_N-1:0] w1a, w1l, w2a, w2l, ready;
   logic            iss_found, disp_found;
   logic [RS_SIZE_BIT-1:0] iss_idx, disp_idx;
   logic d1a, d1l, d2a, d2l;

   assign rs_full      = &busy_q;
   assign alu_input    = alu_input_q;
   assign arith_type   = arith_type_q;
   assign r1_val       = r1_val_q;
   assign r2_val       = r2_val_q;
   assign issue_rob_id = issue_rob_id_q;

   // Match pending tags against both broadcasts and derive issue readiness.
   always_comb begin
      w1a   = '0;
      w1l   = '0;
      w2a   = '0;
      w2l   = '0;
      ready = '0;
      for (int i = 0; i < RS_N; i++) begin
         w1a[i] = busy_q[i] & p1_q[i] & alu_fi & (q1_q[i] == alu_rob_id);
         w1l[i] = busy_q[i] & p1_q[i] & lsb_fi & (q1_q[i] == lsb_rob_id);
         w2a[i] = busy_q[i] & p2_q[i] & alu_fi & (q2_q[i] == alu_rob_id);
         w2l[i] = busy_q[i] & p2_q[i] & lsb_fi & (q2_q[i] == lsb_rob_id);
`ifdef RS_CDB_BYPASS_EN
         ready[i] = busy_q[i] & (~p1_q[i] | w1a[i] | w1l[i])
                              & (~p2_q[i] | w2a[i] | w2l[i]);
`else
         ready[i] = busy_q[i] & ~p1_q[i] & ~p2_q[i];
`endif
      end
      d1a = inst_r1_has_dep & alu_fi & (inst_r1_dep == alu_rob_id);
      d1l = inst_r1_has_dep & lsb_fi & (inst_r1_dep == lsb_rob_id);
      d2a = inst_r2_has_dep & alu_fi & (inst_r2_dep == alu_rob_id);
      d2l = inst_r2_has_dep & lsb_fi & (inst_r2_dep == lsb_rob_id);
   end

   // Priority pick: lowest ready entry to issue, lowest free entry to fill.
   always_comb begin
      iss_found  = 1'b0;
      iss_idx    = '0;
      disp_found = 1'b0;
      disp_idx   = '0;
      for (int i = 0; i < RS_N; i++) begin
         if (!iss_found && ready[i]) begin
            iss_found = 1'b1;
            iss_idx   = RS_SIZE_BIT'(i);
         end
         if (!disp_found && !busy_q[i]) begin
            disp_found = 1'b1;
            disp_idx   = RS_SIZE_BIT'(i);
         end
      end
   end

   // Next-state: flush, wakeup, issue and dispatch; everything holds when rdy_in is low.
   always_comb begin
      busy_d         = busy_q;
      p1_d           = p1_q;
      p2_d           = p2_q;
      ent_type_d     = ent_type_q;
      ent_rob_d      = ent_rob_q;
      v1_d           = v1_q;
      v2_d           = v2_q;
      q1_d           = q1_q;
      q2_d           = q2_q;
      alu_input_d    = alu_input_q;
      arith_type_d   = arith_type_q;
      r1_val_d       = r1_val_q;
      r2_val_d       = r2_val_q;
      issue_rob_id_d = issue_rob_id_q;
      if (rdy_in) begin
         if (rob_clear) begin
            busy_d         = '0;
            alu_input_d    = 1'b0;
            issue_rob_id_d = '0;
         end else begin
            for (int i = 0; i < RS_N; i++) begin
               // ALU port has priority when both ports carry the same tag
               if (w1a[i]) begin
                  v1_d[i] = alu_res;
                  p1_d[i] = 1'b0;
               end else if (w1l[i]) begin
                  v1_d[i] = lsb_res;
                  p1_d[i] = 1'b0;
               end
               if (w2a[i]) begin
                  v2_d[i] = alu_res;
                  p2_d[i] = 1'b0;
               end else if (w2l[i]) begin
                  v2_d[i] = lsb_res;
                  p2_d[i] = 1'b0;
               end
            end
            if (iss_found) begin
               busy_d[iss_idx] = 1'b0;
               alu_input_d     = 1'b1;
               arith_type_d    = ent_type_q[iss_idx];
               issue_rob_id_d  = ent_rob_q[iss_idx];
               r1_val_d        = v1_q[iss_idx];
               r2_val_d        = v2_q[iss_idx];
`ifdef RS_CDB_BYPASS_EN
               if (w1a[iss_idx])      r1_val_d = alu_res;
               else if (w1l[iss_idx]) r1_val_d = lsb_res;
               if (w2a[iss_idx])      r2_val_d = alu_res;
               else if (w2l[iss_idx]) r2_val_d = lsb_res;
`endif
            end else begin
               alu_input_d    = 1'b0;
               issue_rob_id_d = '0;
            end
            if (inst_valid && disp_found) begin
               busy_d[disp_idx]     = 1'b1;
               ent_type_d[disp_idx] = inst_type;
               ent_rob_d[disp_idx]  = inst_rob_id;
               q1_d[disp_idx]       = inst_r1_dep;
               q2_d[disp_idx]       = inst_r2_dep;
               // a producer broadcasting in the dispatch cycle resolves the operand at once
               p1_d[disp_idx] = inst_r1_has_dep & ~d1a & ~d1l;
               p2_d[disp_idx] = inst_r2_has_dep & ~d2a & ~d2l;
               v1_d[disp_idx] = d1a ? alu_res : (d1l ? lsb_res : inst_r1_val);
               v2_d[disp_idx] = d2a ? alu_res : (d2l ? lsb_res : inst_r2_val);
            end
         end
      end
   end

   // Control and issue registers with asynchronous reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy_q         <= '0;
         p1_q           <= '0;
         p2_q           <= '0;
         alu_input_q    <= 1'b0;
         arith_type_q   <= '0;
         r1_val_q       <= '0;
         r2_val_q       <= '0;
         issue_rob_id_q <= '0;
      end else begin
         busy_q         <= busy_d;
         p1_q           <= p1_d;
         p2_q           <= p2_d;
         alu_input_q    <= alu_input_d;
         arith_type_q   <= arith_type_d;
         r1_val_q       <= r1_val_d;
         r2_val_q       <= r2_val_d;
         issue_rob_id_q <= issue_rob_id_d;
      end
   end

   // Entry payload storage.
   always_ff @(posedge clk_in) begin
      ent_type_q <= ent_type_d;
      ent_rob_q  <= ent_rob_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      q1_q       <= q1_d;
      q2_q       <= q2_d;
   end

endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed bench for rs_alu with a scoreboard of expected issues.
// Stimulus pushes {type, r1, r2, rob, cycle} for each issue it expects; a
// monitor on the falling edge pops and compares whenever alu_input is high.
module tb_rs_alu;
   localparam int TW = 5;
   localparam int RW = 4;
`ifdef RS_CDB_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   logic clk_in = 1'b0;
   logic rst_in, rdy_in, rob_clear, inst_valid;
   logic [TW-1:0] inst_type;
   logic [31:0] inst_r1_val, inst_r2_val;
   logic inst_r1_has_dep, inst_r2_has_dep;
   logic [RW-1:0] inst_r1_dep, inst_r2_dep, inst_rob_id;
   logic rs_full;
   logic alu_fi, lsb_fi;
   logic [RW-1:0] alu_rob_id, lsb_rob_id;
   logic [31:0] alu_res, lsb_res;
   logic alu_input;
   logic [TW-1:0] arith_type;
   logic [31:0] r1_val, r2_val;
   logic [RW-1:0] issue_rob_id;

   typedef struct packed {
      logic [TW-1:0] t;
      logic [31:0]   r1;
      logic [31:0]   r2;
      logic [RW-1:0] rob;
      logic [31:0]   at;
   } exp_t;

   exp_t exp_q[$];
   int n_cmp = 0;
   int n_fail = 0;
   logic [31:0] cyc = 0;
   logic [31:0] m;

   rs_alu dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
      .inst_valid(inst_valid), .inst_type(inst_type),
      .inst_r1_val(inst_r1_val), .inst_r2_val(inst_r2_val),
      .inst_r1_has_dep(inst_r1_has_dep), .inst_r2_has_dep(inst_r2_has_dep),
      .inst_r1_dep(inst_r1_dep), .inst_r2_dep(inst_r2_dep),
      .inst_rob_id(inst_rob_id), .rs_full(rs_full),
      .alu_fi(alu_fi), .alu_rob_id(alu_rob_id), .alu_res(alu_res),
      .lsb_fi(lsb_fi), .lsb_rob_id(lsb_rob_id), .lsb_res(lsb_res),
      .alu_input(alu_input), .arith_type(arith_type),
      .r1_val(r1_val), .r2_val(r2_val), .issue_rob_id(issue_rob_id)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 32'd1;

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic expect_issue(input logic [TW-1:0] t, input logic [31:0] a,
                               input logic [31:0] b, input logic [RW-1:0] rob,
                               input logic [31:0] at);
      exp_t e;
      e.t = t; e.r1 = a; e.r2 = b; e.rob = rob; e.at = at;
      exp_q.push_back(e);
   endtask

   task automatic dispatch(input logic [TW-1:0] t, input logic [31:0] a, input logic [31:0] b,
                           input logic da, input logic [RW-1:0] qa,
                           input logic db, input logic [RW-1:0] qb,
                           input logic [RW-1:0] rob);
      inst_valid = 1'b1; inst_type = t; inst_r1_val = a; inst_r2_val = b;
      inst_r1_has_dep = da; inst_r1_dep = qa; inst_r2_has_dep = db; inst_r2_dep = qb;
      inst_rob_id = rob;
      step(1);
      inst_valid = 1'b0; inst_r1_has_dep = 1'b0; inst_r2_has_dep = 1'b0;
   endtask

   // Scoreboard monitor: every issue seen must match the oldest expectation.
   always @(negedge clk_in) begin
      if (!rst_in && alu_input) begin
         if (exp_q.size() == 0) begin
            check("spurious_issue", 64'(alu_input), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("issue_cycle", 64'(cyc), 64'(e.at));
            check("issue_type", 64'(arith_type), 64'(e.t));
            check("issue_r1", 64'(r1_val), 64'(e.r1));
            check("issue_r2", 64'(r2_val), 64'(e.r2));
            check("issue_rob", 64'(issue_rob_id), 64'(e.rob));
         end
      end
   end

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; inst_valid = 1'b0;
      inst_type = '0; inst_r1_val = '0; inst_r2_val = '0;
      inst_r1_has_dep = 1'b0; inst_r2_has_dep = 1'b0;
      inst_r1_dep = '0; inst_r2_dep = '0; inst_rob_id = '0;
      alu_fi = 1'b0; alu_rob_id = '0; alu_res = '0;
      lsb_fi = 1'b0; lsb_rob_id = '0; lsb_res = '0;
      #2;
      check("rst_alu_input", 64'(alu_input), 64'd0);
      check("rst_rs_full", 64'(rs_full), 64'd0);
      check("rst_issue_rob", 64'(issue_rob_id), 64'd0);
      check("rst_r1_val", 64'(r1_val), 64'd0);
      step(2);
      rst_in = 1'b0;
      step(1);

      // ADD 5 + 7, rob 3: issue two cycles after dispatch
      expect_issue(5'b0_000_0, 32'd5, 32'd7, 4'd3, cyc + 32'd2);
      dispatch(5'b0_000_0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
      step(3);

      // SUB with r1 waiting on tag 4, woken by the ALU port
      dispatch(5'b0_000_1, 32'hDEAD, 32'd9, 1'b1, 4'd4, 1'b0, 4'd0, 4'd6);
      step(2);
      m = cyc;
      expect_issue(5'b0_000_1, 32'h10, 32'd9, 4'd6, m + 32'(2 - BYP));
      alu_fi = 1'b1; alu_rob_id = 4'd4; alu_res = 32'h10;
      step(1);
      alu_fi = 1'b0;
      step(3);

      // r2 dep resolved by a same-cycle LSB broadcast at dispatch
      expect_issue(5'b1_001_0, 32'd1, 32'hABCD, 4'd7, cyc + 32'd2);
      lsb_fi = 1'b1; lsb_rob_id = 4'd2; lsb_res = 32'hABCD;
      dispatch(5'b1_001_0, 32'd1, 32'h0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd7);
      lsb_fi = 1'b0;
      step(3);

      // both ports broadcast the same tag: ALU value wins
      dispatch(5'b0_100_0, 32'h0, 32'd2, 1'b1, 4'd5, 1'b0, 4'd0, 4'd1);
      m = cyc;
      expect_issue(5'b0_100_0, 32'h55, 32'd2, 4'd1, m + 32'(2 - BYP));
      alu_fi = 1'b1; alu_rob_id = 4'd5; alu_res = 32'h55;
      lsb_fi = 1'b1; lsb_rob_id = 4'd5; lsb_res = 32'h66;
      step(1);
      alu_fi = 1'b0; lsb_fi = 1'b0;
      step(3);

      // fill all eight entries with operands that never arrive
      for (int k = 0; k < 8; k++) begin
         dispatch(5'b0_000_0, 32'h0, 32'(k), 1'b1, 4'(8 + k), 1'b0, 4'd0, 4'(k));
         if (k == 6) check("full_after_7", 64'(rs_full), 64'd0);
      end
      check("full_after_8", 64'(rs_full), 64'd1);
      m = cyc;
      expect_issue(5'b0_000_0, 32'h33, 32'd3, 4'd3, m + 32'(2 - BYP));
      lsb_fi = 1'b1; lsb_rob_id = 4'd11; lsb_res = 32'h33;
      step(1);
      lsb_fi = 1'b0;
      check("full_after_wake", 64'(rs_full), 64'(1 - BYP));
      step(1);
      check("full_after_issue", 64'(rs_full), 64'd0);
      rob_clear = 1'b1;
      step(1);
      rob_clear = 1'b0;
      check("clear_rs_full", 64'(rs_full), 64'd0);
      check("clear_alu_input", 64'(alu_input), 64'd0);

      // three entries become ready together, then a flush discards them
      for (int k = 0; k < 3; k++)
         dispatch(5'b0_110_0, 32'h0, 32'(256 + k), 1'b1, 4'd12, 1'b0, 4'd0, 4'(8 + k));
      m = cyc;
      if (BYP != 0) expect_issue(5'b0_110_0, 32'h77, 32'h100, 4'd8, m + 32'd1);
      alu_fi = 1'b1; alu_rob_id = 4'd12; alu_res = 32'h77;
      step(1);
      alu_fi = 1'b0;
      rob_clear = 1'b1;
      step(1);
      rob_clear = 1'b0;
      check("flush_alu_input", 64'(alu_input), 64'd0);
      check("flush_rs_full", 64'(rs_full), 64'd0);
      step(4);

      // dispatch while rdy_in is low is ignored
      rdy_in = 1'b0;
      dispatch(5'b0_000_0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
      step(1);
      rdy_in = 1'b1;
      check("stall_no_dispatch_full", 64'(rs_full), 64'd0);
      step(3);

      // rdy_in low after dispatch delays the issue by the stalled cycles
      expect_issue(5'b0_010_1, 32'h11, 32'h22, 4'd9, cyc + 32'd4);
      dispatch(5'b0_010_1, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
      rdy_in = 1'b0;
      step(2);
      rdy_in = 1'b1;
      step(3);

      // reset mid-operation with two blocked entries and a live issue
      dispatch(5'b0_000_0, 32'h0, 32'd0, 1'b1, 4'd13, 1'b0, 4'd0, 4'd2);
      dispatch(5'b0_000_0, 32'h0, 32'd0, 1'b1, 4'd13, 1'b0, 4'd0, 4'd4);
      expect_issue(5'b0_111_0, 32'hAA, 32'hBB, 4'd5, cyc + 32'd2);
      dispatch(5'b0_111_0, 32'hAA, 32'hBB, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
      step(1);
      @(negedge clk_in);
      #1;
      rst_in = 1'b1;
      #1;
      check("mid_rst_alu_input", 64'(alu_input), 64'd0);
      check("mid_rst_r1_val", 64'(r1_val), 64'd0);
      check("mid_rst_r2_val", 64'(r2_val), 64'd0);
      check("mid_rst_issue_rob", 64'(issue_rob_id), 64'd0);
      check("mid_rst_arith_type", 64'(arith_type), 64'd0);
      step(1);
      rst_in = 1'b0;
      alu_fi = 1'b1; alu_rob_id = 4'd13; alu_res = 32'h99;
      step(1);
      alu_fi = 1'b0;
      step(4);
      check("post_rst_rs_full", 64'(rs_full), 64'd0);

      check("leftover_expected", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/rs_alu.md
# rs_alu

Reservation station for arithmetic and branch-compare instructions: buffers dispatched instructions until both operands are available, snoops the ALU and LSB result broadcasts (CDB) for operand wakeup, and issues at most one ready instruction per cycle to the single-cycle ALU. Sits between the decoder/dispatch stage and the ALU; its issue outputs drive the ALU's `alu_input`, `arith_type`, `r1_val`, `r2_val` and `inst_rob_id` inputs directly.

## Interface
- `RS_SIZE_BIT`, default 3: log2 of entry count (8 entries).
- `clk_in` in 1: clock clk_in.
- `rst_in` in 1: reset rst_in, asynchronous, active-high.
- `rdy_in` in 1: all state frozen when low.
- `rob_clear` in 1: misprediction flush; honoured only when `rdy_in` is high.
- `inst_valid` in 1: dispatch strobe.
- `inst_type` in `RS_TYPE_BIT`: {is_branch, func3, func7 bit}, passed through unchanged.
- `inst_r1_val`, `inst_r2_val` in 32: operand values; ignored when the matching dep flag is set.
- `inst_r1_has_dep`, `inst_r2_has_dep` in 1: operand still pending.
- `inst_r1_dep`, `inst_r2_dep` in `ROB_SIZE_BIT`: producer ROB tags.
- `inst_rob_id` in `ROB_SIZE_BIT`: destination ROB tag.
- `rs_full` out 1: no free entry.
- `alu_fi`, `lsb_fi` in 1: CDB broadcast valid for ALU and LSB.
- `alu_rob_id`, `lsb_rob_id` in `ROB_SIZE_BIT`; `alu_res`, `lsb_res` in 32: broadcast tag and value.
- `alu_input` out 1, `arith_type` out `RS_TYPE_BIT`, `r1_val`, `r2_val` out 32, `issue_rob_id` out `ROB_SIZE_BIT`: registered issue to the ALU.

## Operation
- Per entry: busy, type, rob_id, v1/v2 (32), q1/q2 tag, p1/p2 pending flag.
- Dispatch: when `inst_valid` is high, write to the lowest-index non-busy entry. Dispatch is undefined while `rs_full` is high; upstream must hold off.
- Dispatch forwarding, always on: a dispatched operand with its dep set whose tag matches a valid CDB broadcast in the same cycle is stored resolved with the broadcast value.
- Wakeup: each busy entry with pN set compares qN against both CDB ports. On a match, vN takes the result and pN clears. If both ports match the same tag, ALU wins.
- Issue select: the lowest-index busy entry with p1 = p2 = 0. The selected entry is freed in the same cycle.
- Issue register: `alu_input` <= 1 with that entry's fields, else `alu_input` <= 0 and `issue_rob_id` <= 0. Other issue outputs hold their values when nothing issues.
- `rs_full` is combinational: AND of all busy bits. It does not credit a same-cycle issue.
- `rob_clear` with `rdy_in`: all busy bits are cleared, `alu_input` <= 0, and dispatch and issue in that cycle are discarded.
- Reset: all busy bits and pending flags cleared; every output is 0 (`rs_full` = 0).

## Timing
- Cycle N: dispatch of an instruction with no deps.
- Cycle N+1: the entry is busy and eligible for issue.
- Cycle N+2: `alu_input` is high.
- Cycle N+3: ALU `alu_fi` is high.
- Wakeup by a CDB broadcast in cycle M: see Configuration.
- Issue and dispatch may target the same slot in one cycle only if the slot was free at the start of that cycle. A freed slot is reusable the next cycle.
- `rdy_in` low: no dispatch, wakeup, issue or output change. CDB inputs are ignored that cycle.

## Configuration
- `RS_CDB_BYPASS_EN` defined:
  - Ready evaluation also treats an operand as resolved when its tag matches a CDB broadcast in the current cycle.
  - An entry woken in cycle M may issue in cycle M, with the broadcast value muxed onto `r1_val`/`r2_val`.
- `RS_CDB_BYPASS_EN` undefined:
  - A woken entry is first eligible in cycle M+1.
  - Issue operands come only from entry storage.

## Test plan
- Dispatch ADD, r1 = 5, r2 = 7, no deps, rob 3 in cycle 0 -> cycle 2: `alu_input` = 1, `r1_val` = 5, `r2_val` = 7, `issue_rob_id` = 3; cycle 3: `alu_input` = 0.
- Dispatch SUB, r1 dep on tag 4, rob 6; `alu_fi` with tag 4, result 0x10 in cycle 5:
  - with bypass: issue register loads in cycle 5, `r1_val` = 0x10;
  - without bypass: issue register loads in cycle 6.
- Dispatch with r2 dep on tag 2 in the same cycle that `lsb_fi` broadcasts tag 2, value 0xABCD -> the entry issues with `r2_val` = 0xABCD and never stalls.
- Eight dispatches whose deps are never broadcast -> `rs_full` = 1 after the 8th. Broadcast one tag -> that entry issues and `rs_full` drops the cycle after issue.
- Three ready entries, then `rob_clear` -> `alu_input` = 0 next cycle, `rs_full` = 0, no further issue.
- Assert `rst_in` mid-operation with entries busy -> all outputs 0 immediately, no issue after release.
